// File: rtl/sequenciador_leds_pkg.sv
// Shared definitions for the LED sequence player: FSM state codes and
// default step timings (in clock cycles).
package sequenciador_leds_pkg;

   // State codes double as the value shown on the hexa7seg debug display.
   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      ACESO   = 4'd1,
      APAGADO = 4'd2,
      FIM     = 4'd3
   } estado_t;

   localparam int T_ON_LENTO_DEF   = 1000;
   localparam int T_OFF_LENTO_DEF  = 500;
   localparam int T_ON_RAPIDO_DEF  = 500;
   localparam int T_OFF_RAPIDO_DEF = 250;

endpackage

// File: rtl/sequenciador_leds_timer_exibicao.sv
// Display-phase timer: 16-bit up counter with synchronous clear and a
// terminal flag raised on the last cycle of a modulo-long interval.
module timer_exibicao (
   input  logic        clock,
   input  logic        reset,
   input  logic        zera,
   input  logic        conta,
   input  logic [15:0] modulo,
   output logic        fim
);

   logic [15:0] count_q;

   // Counter register: clear has priority over counting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)      count_q <= '0;
      else if (zera)  count_q <= '0;
      else if (conta) count_q <= count_q + 16'd1;
   end

   assign fim = (count_q == (modulo - 16'd1));

endmodule

// File: rtl/sequenciador_leds.sv
// LED sequence player: steps through memory addresses 0..limite, lighting
// the LEDs with each stored pattern for T_ON cycles followed by T_OFF dark
// cycles, then pulses pronto. Speed and length are captured at start.
module sequenciador_leds
   import sequenciador_leds_pkg::*;
#(
   parameter int T_ON_LENTO   = T_ON_LENTO_DEF,
   parameter int T_OFF_LENTO  = T_OFF_LENTO_DEF,
   parameter int T_ON_RAPIDO  = T_ON_RAPIDO_DEF,
   parameter int T_OFF_RAPIDO = T_OFF_RAPIDO_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       cancelar,
   input  logic       dificuldade,
   input  logic [3:0] limite,
   input  logic [7:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [7:0] leds,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   if (T_ON_LENTO < 1 || T_ON_LENTO > 65535 || T_OFF_LENTO < 1 || T_OFF_LENTO > 65535 ||
       T_ON_RAPIDO < 1 || T_ON_RAPIDO > 65535 || T_OFF_RAPIDO < 1 || T_OFF_RAPIDO > 65535) begin : g_chk_tempos
      $error("sequenciador_leds: every T_* parameter must lie in 1..65535");
   end

   estado_t     estado_q, estado_d;
   logic [3:0]  endereco_q, endereco_d;
   logic [3:0]  limite_q, limite_d;
   logic        dif_q, dif_d;
   logic        zera, conta, fim;
   logic [15:0] modulo;

   // Interval length comes only from the speed latched at start.
   always_comb begin
      modulo = '0;
      if (estado_q == APAGADO) modulo = dif_q ? 16'(T_OFF_RAPIDO) : 16'(T_OFF_LENTO);
      else                     modulo = dif_q ? 16'(T_ON_RAPIDO)  : 16'(T_ON_LENTO);
   end

   timer_exibicao u_timer (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera),
      .conta  (conta),
      .modulo (modulo),
      .fim    (fim)
   );

   // State and captured-parameter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         endereco_q <= '0;
         limite_q   <= '0;
         dif_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         dif_q      <= dif_d;
      end
   end

   // Next-state logic; cancelar outranks both iniciar and timer expiry.
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      dif_d      = dif_q;
      zera       = 1'b0;
      conta      = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            zera = 1'b1;
            if (!cancelar && iniciar) begin
               estado_d   = ACESO;
               endereco_d = '0;
               limite_d   = limite;
               dif_d      = dificuldade;
            end
         end
         ACESO: begin
            conta = 1'b1;
            if (cancelar) begin
               estado_d = OCIOSO;
               zera     = 1'b1;
            end else if (fim) begin
               estado_d = APAGADO;
               zera     = 1'b1;
            end
         end
         APAGADO: begin
            conta = 1'b1;
            if (cancelar) begin
               estado_d = OCIOSO;
               zera     = 1'b1;
            end else if (fim) begin
               zera = 1'b1;
               if (endereco_q == limite_q) begin
                  estado_d = FIM;
               end else begin
                  estado_d   = ACESO;
                  endereco_d = endereco_q + 4'd1;
               end
            end
         end
         FIM: begin
            zera     = 1'b1;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   assign endereco  = endereco_q;
   assign leds      = (estado_q == ACESO) ? dado_memoria : '0;
   assign ocupado   = (estado_q == ACESO) || (estado_q == APAGADO);
   assign pronto    = (estado_q == FIM);
   assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_leds.sv
// Bench for sequenciador_leds: directed scenarios plus random stimulus,
// compared every cycle against a step/phase arithmetic reference model.
module tb_sequenciador_leds;

   logic       clock, reset, iniciar, cancelar, dificuldade;
   logic [3:0] limite, endereco, db_estado;
   logic [7:0] dado_memoria, leds;
   logic       ocupado, pronto;
   logic [7:0] mem [16];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model state
   bit         m_busy, m_fim;
   int         m_k;
   logic [3:0] m_lim, m_addr;
   logic       m_dif;

   sequenciador_leds #(
      .T_ON_LENTO   (4),
      .T_OFF_LENTO  (2),
      .T_ON_RAPIDO  (2),
      .T_OFF_RAPIDO (1)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .cancelar     (cancelar),
      .dificuldade  (dificuldade),
      .limite       (limite),
      .dado_memoria (dado_memoria),
      .endereco     (endereco),
      .leds         (leds),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   assign dado_memoria = mem[endereco];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int t_on(input logic d);
      return d ? 2 : 4;
   endfunction

   function automatic int t_off(input logic d);
      return d ? 1 : 2;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_fim = 0; m_k = 0; m_addr = '0; m_lim = '0; m_dif = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_edge();
      int per;
      if (reset) begin
         model_reset();
      end else if (m_fim) begin
         m_fim = 0;
      end else if (m_busy) begin
         per = t_on(m_dif) + t_off(m_dif);
         if (cancelar) m_busy = 0;
         else begin
            m_k++;
            if (m_k == (int'(m_lim) + 1) * per) begin
               m_busy = 0;
               m_fim  = 1;
            end else begin
               m_addr = 4'(m_k / per);
            end
         end
      end else if (iniciar && !cancelar) begin
         m_busy = 1; m_k = 0; m_lim = limite; m_dif = dificuldade; m_addr = '0;
      end
   endtask

   task automatic compare_all();
      int per, ph;
      logic [7:0] e_leds;
      logic [3:0] e_db;
      logic       e_ocup, e_pronto;
      e_leds = '0; e_db = 4'd0; e_ocup = 1'b0; e_pronto = 1'b0;
      if (m_busy) begin
         per = t_on(m_dif) + t_off(m_dif);
         ph  = m_k % per;
         e_ocup = 1'b1;
         if (ph < t_on(m_dif)) begin
            e_leds = mem[m_addr];
            e_db   = 4'd1;
         end else begin
            e_db   = 4'd2;
         end
      end else if (m_fim) begin
         e_pronto = 1'b1;
         e_db     = 4'd3;
      end
      check("endereco", 32'(endereco), 32'(m_addr));
      check("leds", 32'(leds), 32'(e_leds));
      check("ocupado", 32'(ocupado), 32'(e_ocup));
      check("pronto", 32'(pronto), 32'(e_pronto));
      check("db_estado", 32'(db_estado), 32'(e_db));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic start_run(input logic [3:0] lim, input logic d);
      limite = lim; dificuldade = d; iniciar = 1'b1;
      step();
      iniciar = 1'b0;
   endtask

   // Counts edges after the iniciar edge until pronto; optionally jiggles
   // iniciar and dificuldade, which must not disturb the running sequence.
   task automatic wait_pronto(input string tag, input int exp_lat, input bit agitar);
      int n = 0;
      while (pronto !== 1'b1 && n < 300) begin
         if (agitar) begin
            iniciar     = 1'($urandom);
            dificuldade = 1'($urandom);
         end
         step();
         n++;
      end
      iniciar = 1'b0;
      check(tag, 32'(n), 32'(exp_lat));
      step();
   endtask

   initial begin
      reset = 1'b0; iniciar = 1'b0; cancelar = 1'b0; dificuldade = 1'b0; limite = '0;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      model_reset();
      #1 reset = 1'b1;
      #1 compare_all();
      step();
      reset = 1'b0;
      step();

      // Scenario 1: three slow steps
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04;
      start_run(4'd2, 1'b0);
      wait_pronto("latencia_s1", 18, 1'b0);

      // Scenario 2: single fast step
      start_run(4'd0, 1'b1);
      wait_pronto("latencia_s2", 3, 1'b0);

      // Scenario 3: full sixteen-step run
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      start_run(4'd15, 1'b0);
      wait_pronto("latencia_s3", 96, 1'b0);
      check("endereco_fim_s3", 32'(endereco), 32'd15);

      // Scenario 4: cancel in the second lit cycle of the first step
      start_run(4'd3, 1'b0);
      step();
      cancelar = 1'b1;
      step();
      cancelar = 1'b0;
      check("cancel_ocupado", 32'(ocupado), 32'd0);
      for (int i = 0; i < 30; i++) step();

      // iniciar and cancelar together while idle: stay idle
      iniciar = 1'b1; cancelar = 1'b1;
      step();
      iniciar = 1'b0; cancelar = 1'b0;
      check("ini_cancel_ocioso", 32'(db_estado), 32'd0);
      step();

      // Scenario 5: iniciar and dificuldade jiggled during playback
      start_run(4'd2, 1'b0);
      wait_pronto("latencia_s5", 18, 1'b1);
      dificuldade = 1'b0;
      step();

      // Scenario 6: asynchronous reset in the first dark cycle
      start_run(4'd3, 1'b0);
      for (int i = 0; i < 4; i++) step();
      check("s6_em_apagado", 32'(db_estado), 32'd2);
      #3 reset = 1'b1;
      model_reset();
      #1 compare_all();
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 40; i++) step();

      // Random stimulus
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      for (int c = 0; c < 1500; c++) begin
         iniciar     = ($urandom_range(0, 7) == 0);
         cancelar    = ($urandom_range(0, 59) == 0);
         dificuldade = 1'($urandom);
         limite      = 4'($urandom);
         step();
      end
      iniciar = 1'b0; cancelar = 1'b0;
      for (int i = 0; i < 120; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sequenciador_leds.md
SEQUENCIADOR_LEDS -- requirements
Module: sequenciador_leds

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- T_ON_LENTO, 1000: LED-on cycles per step, dificuldade=0.
- T_OFF_LENTO, 500: LED-off cycles per step, dificuldade=0.
- T_ON_RAPIDO, 500: LED-on cycles per step, dificuldade=1.
- T_OFF_RAPIDO, 250: LED-off cycles per step, dificuldade=1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- iniciar, in, 1: start playback, sampled only in OCIOSO.
- cancelar, in, 1: abort playback.
- dificuldade, in, 1: speed select, captured at start.
- limite, in, 4: last memory address to show (0..15), captured at start.
- dado_memoria, in, 8: LED pattern read combinationally at endereco.
- endereco, out, 4: sequence memory address.
- leds, out, 8: board LEDs.
- ocupado, out, 1: playback in progress.
- pronto, out, 1: one-cycle completion pulse.
- db_estado, out, 4: state code for the hexa7seg display.

Function
REQ-003 The FSM SHALL have four states with these db_estado codes: OCIOSO=0, ACESO=1, APAGADO=2, FIM=3.
REQ-004 In OCIOSO with iniciar=1 at an edge, the block SHALL do all of the following at that edge:
- enter ACESO;
- set endereco=0;
- clear the timer;
- latch limite into limite_reg and dificuldade into dif_reg.
REQ-005 The block SHALL ignore iniciar in every state other than OCIOSO.
REQ-006 The block SHALL select T_ON and T_OFF from dif_reg only; a change on the dificuldade input during playback SHALL have no effect.
REQ-007 The block SHALL drive leds=dado_memoria (combinational) while in ACESO, and leds=0 in all other states.
REQ-008 The block SHALL stay in ACESO for exactly T_ON cycles and then enter APAGADO with the timer cleared.
REQ-009 The block SHALL stay in APAGADO for exactly T_OFF cycles, then:
- if endereco==limite_reg, enter FIM;
- otherwise, increment endereco and enter ACESO.
REQ-010 In FIM the block SHALL assert pronto=1 for exactly one cycle and then return to OCIOSO.
REQ-011 endereco SHALL hold its last value in FIM and OCIOSO.
REQ-012 The block SHALL assert ocupado=1 in ACESO and APAGADO only.
REQ-013 Total playback latency from the iniciar edge to pronto high SHALL be (limite_reg+1)*(T_ON+T_OFF) cycles.
REQ-014 cancelar=1 in ACESO or APAGADO SHALL force OCIOSO at the next edge, with no pronto.
REQ-015 cancelar SHALL take priority over the timer expiry in the same cycle.
REQ-016 When iniciar and cancelar are both 1 in OCIOSO, cancelar SHALL win and the block SHALL remain in OCIOSO.
REQ-017 limite=0 SHALL produce exactly one step.
REQ-018 limite=15 SHALL produce sixteen steps without endereco wrap-around.
REQ-019 The timer SHALL be 16 bits wide; every T_* parameter SHALL be in the range 1..65535, enforced by an elaboration check.

Reset
REQ-020 When reset=1 the block SHALL asynchronously force all of the following:
- state OCIOSO;
- endereco=0, timer=0, limite_reg=0, dif_reg=0;
- leds=0, ocupado=0, pronto=0, db_estado=0.
REQ-021 Reset asserted mid-playback SHALL abort immediately, with no pronto pulse after release.

Structure
REQ-022 A shared package SHALL hold the state encoding constants and the four T_* default values.
REQ-023 The timer SHALL be one sub-module, timer_exibicao, with ports zera, conta, modulo and fim, where fim=1 when count==modulo-1.
REQ-024 All other logic SHALL reside in sequenciador_leds.

Verification
REQ-025 The bench SHALL use T_ON_LENTO=4, T_OFF_LENTO=2, T_ON_RAPIDO=2, T_OFF_RAPIDO=1 and cover these scenarios:
- Scenario 1: limite=2, dificuldade=0, memory {01,02,04}, iniciar pulse -> leds=01/02/04 each for 4 cycles, each followed by 2 zero cycles; pronto high exactly 18 cycles after the iniciar edge.
- Scenario 2: limite=0, dificuldade=1 -> a single 2-cycle LED flash; pronto 3 cycles after start; endereco stays 0.
- Scenario 3: limite=15 -> endereco runs 0..15 with no wrap; pronto 96 cycles after start.
- Scenario 4: cancelar in the 2nd ACESO cycle of step 1 -> OCIOSO next edge, leds=0, ocupado=0, no pronto.
- Scenario 5: iniciar pulsed repeatedly and dificuldade toggled mid-playback -> timing unchanged, no restart.
- Scenario 6: reset asserted mid-APAGADO, asynchronously -> all outputs 0 before the next edge; no pronto after release.
